// File: rtl/hist_readout.sv
// Histogram readout: sweeps bins 0..COLOR_RANGE-1 from RAM and streams {bin, count} words
// through a 2-entry output FIFO. Define HIST_RDCLR_EN to clear each bin in RAM after it is read.
module hist_readout #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int COLOR_RANGE   = 256,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] raddr,
  output logic                     rreq,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] out_bin,
  output logic [DATA_WIDTH-1:0]    out_cnt,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef HIST_RDCLR_EN
  ,
  output logic                     wreq,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0]    wdata
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing reads 0..COLOR_RANGE-1 as FIFO room allows
  // DRAIN | all reads issued, emptying in-flight read and FIFO
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_BIN = ADDRESS_WIDTH'(COLOR_RANGE - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_fl;
  logic [ADDRESS_WIDTH-1:0] r_fl_bin;
  logic [ADDRESS_WIDTH-1:0] r_bin [2];
  logic [DATA_WIDTH-1:0]    r_cnt [2];
  logic                     r_wr_ptr;
  logic                     r_rd_ptr;
  logic [1:0]               r_occ;

  logic                     w_pop;
  logic [2:0]               w_level;

  assign w_pop     = (r_occ != 2'd0) && out_ready;
  // words that will be held (FIFO + in-flight) after this cycle's pop
  assign w_level   = {1'b0, r_occ} + {2'b0, r_fl} - {2'b0, w_pop};

  assign raddr     = r_addr;
  assign out_valid = (r_occ != 2'd0);
  assign out_bin   = r_bin[r_rd_ptr];
  assign out_cnt   = r_cnt[r_rd_ptr];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    rreq        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = READ;
      end
      READ: begin
        busy = 1'b1;
        rreq = (w_level < 3'd2);
        if (rreq && (r_addr == LAST_BIN)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!r_fl && (w_level == 3'd0)) w_state_nxt = FIN;
      end
      FIN: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_addr   <= '0;
      r_fl     <= 1'b0;
      r_fl_bin <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_bin[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      r_fl <= rreq;
      if (rreq) begin
        r_fl_bin <= r_addr;
        // terminal compare instead of relying on wrap when COLOR_RANGE == 2^ADDRESS_WIDTH
        r_addr   <= (r_addr == LAST_BIN) ? '0 : r_addr + ADDRESS_WIDTH'(1);
      end
      if (r_fl) begin
        r_bin[r_wr_ptr] <= r_fl_bin;
        r_cnt[r_wr_ptr] <= rdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_fl} - {1'b0, w_pop};
    end
  end

`ifdef HIST_RDCLR_EN
  assign wreq  = r_fl;
  assign waddr = r_fl_bin;
  assign wdata = '0;
`endif

endmodule

// File: tb/tb_hist_readout.sv
// Randomized bench for hist_readout: RAM model plus an expected-word scoreboard
// built from the RAM snapshot taken before each sweep.
module tb_hist_readout;

  logic        clk = 1'b0;
  logic        arstn = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, rreq, out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  raddr, out_bin;
  logic [31:0] rdata, out_cnt;
`ifdef HIST_RDCLR_EN
  logic        wreq;
  logic [7:0]  waddr;
  logic [31:0] wdata;
`endif

  logic [31:0] ram [256];
  logic [31:0] exp_cnt [256];
  int n_pass = 0;
  int n_chk  = 0;

  hist_readout dut (
    .clk(clk), .arstn(arstn), .start(start), .busy(busy), .done(done),
    .raddr(raddr), .rreq(rreq), .rdata(rdata), .out_bin(out_bin),
    .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready)
`ifdef HIST_RDCLR_EN
    , .wreq(wreq), .waddr(waddr), .wdata(wdata)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rreq) rdata <= ram[raddr];
`ifdef HIST_RDCLR_EN
    if (wreq) ram[waddr] <= wdata;
`endif
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_rreq"},  rreq, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_bin"},   out_bin, 0);
    chk({tag, "_cnt"},   out_cnt, 0);
  endtask

  // mode: 0 ready high, 1 ready toggles 1,0,..., 2 random, 3 ready low for 50 cycles
  task automatic run_sweep(input int mode, input bit dbl, input int abort_at, input int exp_done_cyc);
    int cyc = 0, n_words = 0, n_rreq = 0, n_done = 0, done_cyc = -1, post = 0;
    bit pop, prev_stall = 0;
    logic [7:0]  pbin = '0;
    logic [31:0] pcnt = '0;
    for (int i = 0; i < 256; i++) exp_cnt[i] = ram[i];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < 1500 && post < 4) begin
      @(negedge clk);
      cyc++;
      start = dbl && (cyc == 10);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 1);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc > 50);
      endcase
      if (cyc == abort_at) begin
        arstn = 1'b0;
        #1 chk_zero_outputs("abort");
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
        end
        arstn = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("idle_wait_busy", busy, 0);
        end
        start = 1'b0;
        return;
      end
      #1;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end else if (done_cyc >= 0) post++;
      pop = out_valid && out_ready;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_bin", out_bin, pbin);
        chk("stall_cnt", out_cnt, pcnt);
      end
      if (rreq) begin
        chk("rreq_room", ((n_rreq - n_words - int'(pop)) < 2), 1);
        chk("raddr_order", raddr, n_rreq);
        n_rreq++;
      end
      if (pop) begin
        if (n_words < 256) begin
          chk("word_bin", out_bin, n_words);
          chk("word_cnt", out_cnt, exp_cnt[n_words]);
        end else chk("extra_word", 1, 0);
        n_words++;
      end
      if (mode == 3 && cyc == 50) begin
        chk("hold_rreq_max2", (n_rreq <= 2), 1);
        chk("hold_valid", out_valid, 1);
        chk("hold_bin0", out_bin, 0);
      end
      prev_stall = out_valid && !out_ready;
      pbin = out_bin;
      pcnt = out_cnt;
    end
    start = 1'b0;
    chk("busy_after", busy, 0);
    chk("word_total", n_words, 256);
    chk("done_pulses", n_done, 1);
    if (exp_done_cyc > 0) chk("done_cycle", done_cyc, exp_done_cyc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'(i * 3);
    #3 arstn = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    run_sweep(0, 1'b0, 0, 259);
`ifdef HIST_RDCLR_EN
    for (int i = 0; i < 256; i++) chk("ram_cleared", ram[i], 0);
`endif
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_sweep(1, 1'b0, 0, 0);
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_sweep(3, 1'b0, 0, 0);
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_sweep(0, 1'b1, 0, 259);
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_sweep(2, 1'b0, 100, 0);
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_sweep(0, 1'b0, 0, 259);
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_sweep(2, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hist_readout.md
HIST_READOUT -- requirements
Module: hist_readout

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8, bin address width.
REQ-002 Parameter COLOR_RANGE, default 256, number of bins swept (at most 2^ADDRESS_WIDTH).
REQ-003 Parameter DATA_WIDTH, default 32, bin count width.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 arstn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse; begins one readout sweep.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse after the last bin is accepted downstream.
REQ-009 raddr  output  ADDRESS_WIDTH  histogram RAM read address.
REQ-010 rreq  output  1  RAM read strobe; rdata is valid exactly 1 cycle after rreq.
REQ-011 rdata  input  DATA_WIDTH  RAM read data.
REQ-012 out_bin  output  ADDRESS_WIDTH  bin index of the current output word.
REQ-013 out_cnt  output  DATA_WIDTH  count of the current output word.
REQ-014 out_valid  output  1  output word valid.
REQ-015 out_ready  input  1  downstream accept; a transfer occurs when out_valid and out_ready are both high.
REQ-016 wreq, waddr, wdata  output  1/ADDRESS_WIDTH/DATA_WIDTH  RAM clear-write port, present only with HIST_RDCLR_EN.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, FIN.
- IDLE->READ on start.
- READ->DRAIN after the read of bin COLOR_RANGE-1 is issued.
- DRAIN->FIN when the output buffer is empty and no read is in flight.
- FIN->IDLE unconditionally after one cycle.
REQ-018 start is ignored in every state other than IDLE.
REQ-019 In READ, reads are issued in ascending address order 0..COLOR_RANGE-1, at most one per cycle, with each address issued exactly once.
REQ-020 Output buffer: 2-entry FIFO of {bin, count}.
- rreq asserts only when (FIFO occupancy + in-flight reads - pops this cycle) < 2.
- FIFO never overflows; no rdata is dropped.
REQ-021 With out_ready held high, the sweep sustains one word per cycle.
- First out_valid appears 2 cycles after rreq for bin 0.
- done pulses COLOR_RANGE+3 cycles after start.
REQ-022 out_bin/out_cnt hold stable while out_valid is high and out_ready is low.
REQ-023 Output order equals address order; out_bin equals the raddr that produced out_cnt.
REQ-024 Address counter is ADDRESS_WIDTH bits; for COLOR_RANGE = 2^ADDRESS_WIDTH the terminal compare uses COLOR_RANGE-1 and the counter is never relied on to wrap.
REQ-025 done is high only in FIN.
REQ-026 busy is high in READ and DRAIN.
REQ-027 out_valid may be low for arbitrary stretches during backpressure; out_ready toggling every cycle loses no bins.

Reset
REQ-028 On arstn low, outputs immediately clear: busy=0, done=0, rreq=0, raddr=0, out_valid=0, out_bin=0, out_cnt=0, wreq=0, waddr=0, wdata=0.
REQ-029 On arstn low, the FSM enters IDLE and the FIFO and in-flight tracking are cleared.
REQ-030 Reset mid-sweep abandons the sweep with no done pulse.
REQ-031 After reset deassertion, the block waits for a new start.

Configuration
REQ-032 Macro HIST_RDCLR_EN defined: every issued read is followed 1 cycle later by wreq=1, waddr=that address, wdata=0.
- Histogram RAM is left all-zero at sweep end.
- Timing is otherwise unchanged.
REQ-033 Macro HIST_RDCLR_EN undefined: wreq/waddr/wdata ports are absent and RAM contents are untouched.

Verification
REQ-034 RAM bin i = i*3, out_ready=1, start at cycle 0 -> 256 words bin 0..255 with counts 0..765; done pulse at cycle 259; busy low afterward.
REQ-035 out_ready pattern 1,0,1,0 -> same 256 words in order with no duplicates; out_cnt stable across every stall; rreq never issued with 2 words pending.
REQ-036 out_ready=0 for 50 cycles after start -> at most 2 rreq pulses; out_valid held with out_bin=0; then full release -> remaining 254 bins follow.
REQ-037 Second start pulse at cycle 10 of a sweep -> ignored; exactly 256 words and one done pulse.
REQ-038 arstn low at cycle 100 -> all outputs 0 next edge and no done pulse; new start -> complete sweep from bin 0.
REQ-039 With HIST_RDCLR_EN and RAM preloaded to 0xFFFFFFFF -> outputs all 0xFFFFFFFF; 256 wreq with wdata=0; RAM reads back all zero.
